shot_resolver: RTL and testbench
================================

Name: shot_resolver

Overview:
Parametrised successor to the single-cycle hit check. It holds a per-cell ship-ID board and a shot-history map, and resolves each accepted shot into one registered result: MISS, HIT, SUNK, REPEAT or INVALID. It also tracks remaining cells per ship, flags fleet destruction, and counts shots and hits. It sits between the cursor/fire input logic and the display/score logic.

Parameters:
ROWS, 10, board rows
COLS, 10, board columns
NUM_SHIPS, 5, number of ship IDs (1..NUM_SHIPS)
ID_W, 3, ship-ID width; must satisfy 2**ID_W > NUM_SHIPS
CNT_W, 8, width of shot/hit counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  one-cycle pulse; latch ship_map and start a new game
ship_map  in  ROWS*COLS*ID_W  cell i=row*COLS+col at [i*ID_W +: ID_W]; 0=water; IDs >NUM_SHIPS treated as water
busy  out  1  board scan in progress
shot_valid  in  1  shot request
shot_ready  out  1  block can accept a shot
shot_row  in  $clog2(ROWS)  target row
shot_col  in  $clog2(COLS)  target column
res_valid  out  1  one-cycle result strobe
res_code  out  3  0 MISS, 1 HIT, 2 SUNK, 3 REPEAT, 4 INVALID
res_ship  out  ID_W  ship ID for HIT/SUNK, else 0
all_sunk  out  1  level; whole fleet destroyed
shots_fired  out  CNT_W  counted shots, saturating
hits  out  CNT_W  counted hits, saturating

Behaviour:
- Reset:
  - State is EMPTY.
  - Shot map, remaining counters and the latched board are cleared.
  - All outputs are 0.
- FSM states: EMPTY, SCAN, ARMED, DONE.
- EMPTY -> SCAN on load.
  - Latch ship_map.
  - Clear the shot map, the remaining[] counters and both output counters.
  - Set the scan index to 0.
- SCAN:
  - One cell per cycle, index 0..ROWS*COLS-1. For a valid ID, remaining[id]++.
  - busy=1 for exactly ROWS*COLS cycles.
  - On completion: go to ARMED if any ship cell exists, else to DONE with all_sunk=1.
- shot_ready = (state==ARMED). It is a registered-state decode, with no combinational path from shot_valid.
- Accept occurs on shot_valid && shot_ready. The result is registered, so res_valid pulses exactly 1 cycle after acceptance.
- Back-to-back shots are accepted every cycle while in ARMED.
- shot_valid while not ready is ignored and produces no response.
- Resolution, with idx = row*COLS+col, in priority order:
  - row>=ROWS or col>=COLS -> INVALID. No state change, not counted.
  - shot_map[idx] already set -> REPEAT. Not counted.
  - Water -> MISS. Set shot_map[idx]; shots_fired++.
  - Ship id -> set shot_map[idx]; shots_fired++; hits++; remaining[id]--.
    - If remaining[id] reaches 0 -> SUNK, else HIT. res_ship=id.
- Fleet destruction: when the final SUNK leaves every remaining[]==0, all_sunk rises in the same cycle as that res_valid and the FSM goes to DONE.
  - DONE holds all_sunk=1 and shot_ready=0 until load or rst.
- Counters saturate at 2**CNT_W-1.
- Load in any state restarts from SCAN with cleared history, including load mid-scan, which restarts at index 0.
- Load and shot acceptance in the same cycle: load wins, the shot is dropped and no res_valid is issued.
- rst at any time, including mid-scan or mid-result, returns everything to reset values on the next edge.
- res_code and res_ship hold their last values between strobes; only res_valid qualifies them.

Decomposition:
- Shared package battleship_pkg holds:
  - res_code_t enum (MISS, HIT, SUNK, REPEAT, INVALID)
  - fsm state typedef
  - default board constants ROWS, COLS, NUM_SHIPS
- Natural sub-module: shot_map. A ROWS*COLS-bit register with synchronous clear, single-bit set and single-bit read.
- Remaining counters and the FSM stay in the top.

Test Plan:
1. rst held 3 cycles, then released -> busy=0, shot_ready=0, res_valid=0, all_sunk=0, counters 0; shot_valid ignored.
2. Load a map with ship1 at (0,0),(0,1), ship2 at (2,3), rest water -> busy high exactly 100 cycles, then shot_ready=1.
3. Shot (0,5) -> next cycle MISS, shots_fired=1. Shot (0,5) again -> REPEAT, shots_fired stays 1. Shot (10,0) -> INVALID, counters unchanged.
4. Shot (0,0) -> HIT res_ship=1, hits=1. Next cycle shot (0,1) -> SUNK res_ship=1, hits=2, all_sunk=0.
5. Shot (2,3) -> SUNK res_ship=2 with all_sunk=1 in the same cycle, shot_ready=0. Further shot_valid gives no res_valid.
6. Load pulsed at scan index 40, then load coincident with an accepted shot in ARMED, then an all-water map:
   - Restart at index 0; busy lasts 100 cycles from the second load.
   - The coincident shot is dropped with no res_valid.
   - The all-water map ends in DONE with all_sunk=1 right after the scan.

Source files
------------

// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared types and default board constants for the shot resolver
package battleship_pkg;

  localparam int DEF_ROWS      = 10;
  localparam int DEF_COLS      = 10;
  localparam int DEF_NUM_SHIPS = 5;

  typedef enum logic [2:0] {
    RES_MISS    = 3'd0,
    RES_HIT     = 3'd1,
    RES_SUNK    = 3'd2,
    RES_REPEAT  = 3'd3,
    RES_INVALID = 3'd4
  } res_code_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shot_map.sv
// rtl/shot_map.sv - per-cell shot history bitmap with clear, single-bit set and read
module shot_map #(
  parameter int N  = 100,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_bit
);

  logic [N-1:0] bits_q;

  // clear wins over set so a new game never inherits a shot from the old one
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bits_q <= '0;
    end else if (set_en && (32'(set_idx) < N)) begin
      bits_q[set_idx] <= 1'b1;
    end
  end

  // addresses past the board read as never shot
  always_comb begin
    rd_bit = 1'b0;
    if (32'(rd_idx) < N) rd_bit = bits_q[rd_idx];
  end

endmodule

// File: rtl/shot_resolver.sv
// rtl/shot_resolver.sv - board scan, shot resolution, fleet tracking and shot/hit counters
module shot_resolver
  import battleship_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int NUM_SHIPS = DEF_NUM_SHIPS,
  parameter int ID_W      = 3,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [ROWS*COLS*ID_W-1:0]   ship_map,
  output logic                        busy,
  input  logic                        shot_valid,
  output logic                        shot_ready,
  input  logic [$clog2(ROWS)-1:0]     shot_row,
  input  logic [$clog2(COLS)-1:0]     shot_col,
  output logic                        res_valid,
  output logic [2:0]                  res_code,
  output logic [ID_W-1:0]             res_ship,
  output logic                        all_sunk,
  output logic [CNT_W-1:0]            shots_fired,
  output logic [CNT_W-1:0]            hits
);

  localparam int N      = ROWS * COLS;
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int IDX_W  = $clog2(N);
  localparam int LEFT_W = $clog2(N + 1);

  state_t                 state_q, state_d;
  logic [N*ID_W-1:0]      board_q;
  logic [IDX_W-1:0]       scan_idx_q;
  logic [LEFT_W-1:0]      remaining_q [1:NUM_SHIPS];
  logic [LEFT_W-1:0]      cells_left_q;
  logic                   res_valid_q;
  res_code_t              res_code_q;
  logic [ID_W-1:0]        res_ship_q;
  logic [CNT_W-1:0]       shots_q, hits_q;

  logic [ID_W-1:0]        scan_id;
  logic                   scan_is_ship;
  logic                   scan_last;
  logic [IDX_W-1:0]       shot_idx;
  logic [ID_W-1:0]        shot_id;
  logic                   shot_is_ship;
  logic                   in_range;
  logic                   already_shot;
  logic                   accept;
  res_code_t              r_code;
  logic [ID_W-1:0]        r_ship;
  logic                   r_mark;
  logic                   r_hit;

  // board cell under the scan pointer; IDs beyond the fleet count as water
  always_comb begin
    scan_id      = board_q[32'(scan_idx_q) * ID_W +: ID_W];
    scan_is_ship = (scan_id != '0) && (scan_id <= ID_W'(NUM_SHIPS));
    scan_last    = (scan_idx_q == IDX_W'(N - 1));
  end

  // target cell decode; out-of-range coordinates may alias but are caught by in_range first
  always_comb begin
    in_range     = ({1'b0, shot_row} < (RW + 1)'(ROWS)) && ({1'b0, shot_col} < (CW + 1)'(COLS));
    shot_idx     = IDX_W'(shot_row) * IDX_W'(COLS) + IDX_W'(shot_col);
    shot_id      = board_q[32'(shot_idx) * ID_W +: ID_W];
    shot_is_ship = (shot_id != '0) && (shot_id <= ID_W'(NUM_SHIPS));
    shot_ready   = (state_q == ST_ARMED);
    busy         = (state_q == ST_SCAN);
    all_sunk     = (state_q == ST_DONE);
    accept       = shot_valid && shot_ready && !load;
  end

  shot_map #(
    .N  (N),
    .IW (IDX_W)
  ) u_shot_map (
    .clk     (clk),
    .rst     (rst),
    .clr     (load),
    .set_en  (accept && r_mark),
    .set_idx (shot_idx),
    .rd_idx  (shot_idx),
    .rd_bit  (already_shot)
  );

  // shot resolution in priority order: bounds, history, water, ship
  always_comb begin
    r_code = RES_INVALID;
    r_ship = '0;
    r_mark = 1'b0;
    r_hit  = 1'b0;
    if (!in_range) begin
      r_code = RES_INVALID;
    end else if (already_shot) begin
      r_code = RES_REPEAT;
    end else if (!shot_is_ship) begin
      r_code = RES_MISS;
      r_mark = 1'b1;
    end else begin
      r_mark = 1'b1;
      r_hit  = 1'b1;
      r_ship = shot_id;
      r_code = (remaining_q[shot_id] == LEFT_W'(1)) ? RES_SUNK : RES_HIT;
    end
  end

  // next state; load restarts the scan from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = ST_EMPTY;
      ST_SCAN: begin
        if (scan_last) begin
          state_d = ((cells_left_q != '0) || scan_is_ship) ? ST_ARMED : ST_DONE;
        end
      end
      ST_ARMED: begin
        if (accept && r_hit && (cells_left_q == LEFT_W'(1))) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (load) state_d = ST_SCAN;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // latched board and scan pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      board_q    <= '0;
      scan_idx_q <= '0;
    end else if (load) begin
      board_q    <= ship_map;
      scan_idx_q <= '0;
    end else if (state_q == ST_SCAN) begin
      scan_idx_q <= scan_idx_q + IDX_W'(1);
    end
  end

  // per-ship and whole-fleet remaining cell counts; the fleet total detects the final sink
  always_ff @(posedge clk) begin
    if (rst || load) begin
      for (int s = 1; s <= NUM_SHIPS; s++) remaining_q[s] <= '0;
      cells_left_q <= '0;
    end else if ((state_q == ST_SCAN) && scan_is_ship) begin
      remaining_q[scan_id] <= remaining_q[scan_id] + LEFT_W'(1);
      cells_left_q         <= cells_left_q + LEFT_W'(1);
    end else if (accept && r_hit) begin
      remaining_q[shot_id] <= remaining_q[shot_id] - LEFT_W'(1);
      cells_left_q         <= cells_left_q - LEFT_W'(1);
    end
  end

  // saturating shot and hit counters; only MISS/HIT/SUNK count
  always_ff @(posedge clk) begin
    if (rst || load) begin
      shots_q <= '0;
      hits_q  <= '0;
    end else if (accept && r_mark) begin
      if (shots_q != '1)         shots_q <= shots_q + CNT_W'(1);
      if (r_hit && (hits_q != '1)) hits_q <= hits_q + CNT_W'(1);
    end
  end

  // registered result; code and ship hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_code_q  <= RES_MISS;
      res_ship_q  <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_code_q <= r_code;
        res_ship_q <= r_ship;
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_code    = res_code_q;
  assign res_ship    = res_ship_q;
  assign shots_fired = shots_q;
  assign hits        = hits_q;

endmodule

// File: tb/tb_shot_resolver.sv
// tb/tb_shot_resolver.sv - directed self-checking bench for shot_resolver
module tb_shot_resolver;
  import battleship_pkg::*;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int NUM_SHIPS = 5;
  localparam int ID_W = 3;
  localparam int CNT_W = 8;
  localparam int N = ROWS * COLS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 load;
  logic [N*ID_W-1:0]    ship_map;
  logic                 busy;
  logic                 shot_valid;
  logic                 shot_ready;
  logic [3:0]           shot_row;
  logic [3:0]           shot_col;
  logic                 res_valid;
  logic [2:0]           res_code;
  logic [ID_W-1:0]      res_ship;
  logic                 all_sunk;
  logic [CNT_W-1:0]     shots_fired;
  logic [CNT_W-1:0]     hits;

  int checks = 0;
  int failures = 0;
  int n;

  shot_resolver #(
    .ROWS(ROWS), .COLS(COLS), .NUM_SHIPS(NUM_SHIPS), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .ship_map(ship_map), .busy(busy),
    .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_row(shot_row), .shot_col(shot_col),
    .res_valid(res_valid), .res_code(res_code), .res_ship(res_ship), .all_sunk(all_sunk),
    .shots_fired(shots_fired), .hits(hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cell(input int idx, input int id);
    ship_map[idx*ID_W +: ID_W] = ID_W'(id);
  endtask

  task automatic wait_scan(output int cnt);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      tick();
    end
  endtask

  task automatic shoot(input int r, input int c);
    shot_row   = 4'(r);
    shot_col   = 4'(c);
    shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int code, input int ship, input int shots, input int nhits);
    check({tag, "_valid"}, int'(res_valid), 1);
    check({tag, "_code"},  int'(res_code), code);
    check({tag, "_ship"},  int'(res_ship), ship);
    check({tag, "_shots"}, int'(shots_fired), shots);
    check({tag, "_hits"},  int'(hits), nhits);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; shot_valid = 1'b0; shot_row = '0; shot_col = '0; ship_map = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(shot_ready), 0);
    rst = 1'b0;
    shot_valid = 1'b1;
    tick();
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(shot_ready), 0);
    check("idle_res_valid", int'(res_valid), 0);
    check("idle_all_sunk", int'(all_sunk), 0);
    check("idle_shots", int'(shots_fired), 0);
    check("idle_hits", int'(hits), 0);
    tick();
    check("idle_res_valid2", int'(res_valid), 0);
    shot_valid = 1'b0;

    set_cell(0, 1); set_cell(1, 1); set_cell(23, 2); set_cell(50, 6); set_cell(51, 7);
    load = 1'b1;
    tick();
    load = 1'b0;
    ship_map = '0;
    check("scan_busy_start", int'(busy), 1);
    wait_scan(n);
    check("scan_len", n, 100);
    check("armed_ready", int'(shot_ready), 1);
    check("armed_all_sunk", int'(all_sunk), 0);

    shoot(0, 5);
    expect_res("miss", int'(RES_MISS), 0, 1, 0);
    tick();
    check("strobe_one_cycle", int'(res_valid), 0);
    check("hold_code", int'(res_code), int'(RES_MISS));
    shoot(0, 5);
    expect_res("repeat", int'(RES_REPEAT), 0, 1, 0);
    shoot(10, 0);
    expect_res("invalid_row", int'(RES_INVALID), 0, 1, 0);
    shoot(3, 15);
    expect_res("invalid_col", int'(RES_INVALID), 0, 1, 0);
    shoot(5, 0);
    expect_res("id6_water", int'(RES_MISS), 0, 2, 0);

    shot_row = 4'd0; shot_col = 4'd0; shot_valid = 1'b1;
    tick();
    expect_res("hit1", int'(RES_HIT), 1, 3, 1);
    shot_col = 4'd1;
    tick();
    shot_valid = 1'b0;
    expect_res("sunk1", int'(RES_SUNK), 1, 4, 2);
    check("sunk1_all_sunk", int'(all_sunk), 0);
    check("sunk1_ready", int'(shot_ready), 1);
    shoot(0, 0);
    expect_res("repeat_hit", int'(RES_REPEAT), 0, 4, 2);

    shoot(2, 3);
    expect_res("sunk2", int'(RES_SUNK), 2, 5, 3);
    check("fleet_all_sunk", int'(all_sunk), 1);
    check("fleet_ready", int'(shot_ready), 0);
    shot_row = 4'd5; shot_col = 4'd5; shot_valid = 1'b1;
    tick();
    check("done_no_res", int'(res_valid), 0);
    tick();
    shot_valid = 1'b0;
    check("done_no_res2", int'(res_valid), 0);
    check("done_hold_code", int'(res_code), int'(RES_SUNK));
    check("done_hold_ship", int'(res_ship), 2);
    check("done_all_sunk", int'(all_sunk), 1);

    ship_map = '0;
    set_cell(0, 5); set_cell(10, 5); set_cell(99, 3);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("reload_all_sunk", int'(all_sunk), 0);
    repeat (40) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_scan(n);
    check("midscan_restart_len", n, 100);
    shoot(9, 9);
    expect_res("sunk3_last_cell", int'(RES_SUNK), 3, 1, 1);
    check("sunk3_all_sunk", int'(all_sunk), 0);

    shot_row = 4'd0; shot_col = 4'd0; shot_valid = 1'b1; load = 1'b1;
    tick();
    load = 1'b0; shot_valid = 1'b0;
    check("coincide_no_res", int'(res_valid), 0);
    check("coincide_busy", int'(busy), 1);
    check("coincide_shots", int'(shots_fired), 0);
    check("coincide_hits", int'(hits), 0);
    wait_scan(n);
    check("coincide_scan_len", n, 100);
    shoot(0, 0);
    expect_res("after_drop_hit", int'(RES_HIT), 5, 1, 1);

    ship_map = '0;
    set_cell(7, 6);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_scan(n);
    check("water_scan_len", n, 100);
    check("water_all_sunk", int'(all_sunk), 1);
    check("water_ready", int'(shot_ready), 0);
    shoot(0, 0);
    check("water_no_res", int'(res_valid), 0);

    ship_map = '0;
    set_cell(0, 1);
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_all_sunk", int'(all_sunk), 0);
    check("rst_mid_ready", int'(shot_ready), 0);
    check("rst_mid_code", int'(res_code), 0);
    tick();
    check("rst_mid_stays_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
